// File: rtl/run_ctrl_pkg.sv
// run_ctrl_pkg: FSM state type and default parameter values for run_ctrl.
package run_ctrl_pkg;
  typedef enum logic [2:0] {S_IDLE, S_LOAD, S_HOLD, S_RUN, S_FIN} state_t;
  localparam int CYC_W_DEF    = 16;
  localparam int TIMEOUT_DEF  = 4000;
  localparam int HOLD_CYC_DEF = 2;
endpackage

// File: rtl/dm_loader.sv
// dm_loader: data-memory preload port; byte counter, ld handshake, write port.
//   i_clk/i_reset  clock, sync active-high reset
//   i_en           loading enabled (FSM in LOAD)
//   i_clr          clear byte counter
//   i_len          latched load length
//   i_ld_valid/i_ld_data  byte stream in; o_ld_ready accept
//   o_mem_wr_en/o_mem_addr/o_mem_dat  combinational memory write port
//   o_last         final byte accepted this cycle
module dm_loader (
  input  logic       i_clk,
  input  logic       i_reset,
  input  logic       i_en,
  input  logic       i_clr,
  input  logic [7:0] i_len,
  input  logic       i_ld_valid,
  input  logic [7:0] i_ld_data,
  output logic       o_ld_ready,
  output logic       o_mem_wr_en,
  output logic [7:0] o_mem_addr,
  output logic [7:0] o_mem_dat,
  output logic       o_last
);
  logic [7:0] r_cnt;
  // Gating with reset stops writes in the very cycle reset is raised.
  assign o_ld_ready  = i_en && !i_reset;
  assign o_mem_wr_en = o_ld_ready && i_ld_valid;
  assign o_mem_addr  = r_cnt;
  assign o_mem_dat   = i_ld_data;
  assign o_last      = o_mem_wr_en && (r_cnt == i_len - 8'd1);
  always_ff @(posedge i_clk) begin
    if (i_reset || i_clr) r_cnt <= '0;
    else if (o_mem_wr_en) r_cnt <= r_cnt + 8'd1;
  end
endmodule

// File: rtl/run_ctrl.sv
// run_ctrl: sequences preload, core reset hold, timed run and result handshake.
//   i_clk/i_reset      clock, sync active-high reset
//   i_req/o_ack        four-phase run handshake
//   i_load_len         bytes to preload (0 skips load)
//   i_ld_valid/i_ld_data/o_ld_ready  preload byte stream
//   o_mem_wr_en/o_mem_addr/o_mem_dat data-memory write port
//   o_core_reset/i_core_done         processor control
//   o_timeout/o_cycles               result of last run; o_busy not IDLE
module run_ctrl
  import run_ctrl_pkg::*;
#(
  parameter int CYC_W    = CYC_W_DEF,
  parameter int TIMEOUT  = TIMEOUT_DEF,
  parameter int HOLD_CYC = HOLD_CYC_DEF
) (
  input  logic             i_clk,
  input  logic             i_reset,
  input  logic             i_req,
  input  logic [7:0]       i_load_len,
  input  logic             i_ld_valid,
  input  logic [7:0]       i_ld_data,
  output logic             o_ld_ready,
  output logic             o_mem_wr_en,
  output logic [7:0]       o_mem_addr,
  output logic [7:0]       o_mem_dat,
  output logic             o_core_reset,
  input  logic             i_core_done,
  output logic             o_ack,
  output logic             o_timeout,
  output logic [CYC_W-1:0] o_cycles,
  output logic             o_busy
);
  localparam int HW = $clog2(HOLD_CYC + 1);
  state_t           r_state, w_next;
  logic [7:0]       r_len;
  logic [CYC_W-1:0] r_cyc, w_cyc_inc;
  logic [HW-1:0]    r_hold;
  logic             r_to, w_last, w_hold_done, w_lim;

  dm_loader u_loader (
    .i_clk       (i_clk),
    .i_reset     (i_reset),
    .i_en        (r_state == S_LOAD),
    .i_clr       (r_state == S_IDLE),
    .i_len       (r_len),
    .i_ld_valid  (i_ld_valid),
    .i_ld_data   (i_ld_data),
    .o_ld_ready  (o_ld_ready),
    .o_mem_wr_en (o_mem_wr_en),
    .o_mem_addr  (o_mem_addr),
    .o_mem_dat   (o_mem_dat),
    .o_last      (w_last)
  );

  always_comb begin
    w_next      = r_state;
    w_cyc_inc   = r_cyc + CYC_W'(1);
    w_hold_done = r_hold == HW'(HOLD_CYC - 1);
    w_lim       = w_cyc_inc == CYC_W'(TIMEOUT);
    case (r_state)
      S_IDLE:  if (i_req) w_next = (i_load_len != 8'd0) ? S_LOAD : S_HOLD;
      S_LOAD:  if (w_last) w_next = S_HOLD;
      S_HOLD:  if (w_hold_done) w_next = S_RUN;
      S_RUN:   if (i_core_done || w_lim) w_next = S_FIN;
      S_FIN:   if (!i_req) w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_state <= S_IDLE;
      r_len   <= '0;
      r_cyc   <= '0;
      r_to    <= 1'b0;
      r_hold  <= '0;
    end else begin
      r_state <= w_next;
      r_hold  <= (r_state == S_HOLD) ? r_hold + HW'(1) : '0;
      if (r_state == S_IDLE && i_req) begin
        r_len <= i_load_len;
        r_cyc <= '0;
        r_to  <= 1'b0;
      end
      // Done takes priority over the limit reached in the same cycle.
      if (r_state == S_RUN) begin
        r_cyc <= w_cyc_inc;
        r_to  <= !i_core_done && w_lim;
      end
    end
  end

  assign o_core_reset = i_reset || r_state != S_RUN;
  assign o_ack        = !i_reset && r_state == S_FIN;
  assign o_busy       = !i_reset && r_state != S_IDLE;
  assign o_timeout    = !i_reset && r_to;
  assign o_cycles     = i_reset ? '0 : r_cyc;
endmodule

// File: tb/tb_run_ctrl.sv
// tb_run_ctrl: vector table, hand-written corner sequences and random runs for run_ctrl.
module tb_run_ctrl;
  localparam int TO = 20;
  logic clk = 0, reset = 1, req = 0, ld_valid = 0, core_done = 0;
  logic [7:0] load_len = 0, ld_data = 0;
  logic ld_ready, mem_wr_en, core_reset, ack, timeout, busy;
  logic [7:0] mem_addr, mem_dat;
  logic [15:0] cycles;
  logic [7:0] bytes [256];
  int checks = 0, failures = 0;

  typedef struct {int len; int done_at; int exp_cyc; int exp_to;} vec_t;
  vec_t vecs [7];

  run_ctrl #(.CYC_W(16), .TIMEOUT(TO), .HOLD_CYC(2)) dut (
    .i_clk(clk), .i_reset(reset), .i_req(req), .i_load_len(load_len),
    .i_ld_valid(ld_valid), .i_ld_data(ld_data), .o_ld_ready(ld_ready),
    .o_mem_wr_en(mem_wr_en), .o_mem_addr(mem_addr), .o_mem_dat(mem_dat),
    .o_core_reset(core_reset), .i_core_done(core_done), .o_ack(ack),
    .o_timeout(timeout), .o_cycles(cycles), .o_busy(busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic run_one(input int len, input int done_at, input int exp_cyc, input int exp_to);
    int k = 0, run_n = 0, hold_n = 0;
    bit gap = 0, done = 0;
    @(negedge clk); #1;
    chk("idle_busy", busy, 0);
    chk("idle_ack", ack, 0);
    chk("idle_core_reset", core_reset, 1);
    req = 1; load_len = 8'(len); ld_valid = 1; core_done = 0;
    #1 chk("idle_no_write", mem_wr_en, 0);
    for (int it = 0; it < 500; it++) begin
      @(negedge clk); #1;
      if (ack) begin done = 1; break; end
      if (it == 0) chk("cycles_cleared", cycles, 0);
      if (!core_reset) run_n++;
      if (busy && core_reset && !ld_ready) hold_n++;
      req = 1'($urandom_range(0, 1));
      if (k == 1 && !gap) begin ld_valid = 0; gap = 1; end
      else ld_valid = ($urandom_range(0, 3) != 0);
      ld_data = (k < len) ? bytes[k] : 8'($urandom);
      core_done = core_reset ? 1'($urandom_range(0, 1)) : (run_n == done_at);
      #1;
      if (mem_wr_en) begin
        chk("wr_addr", mem_addr, k);
        if (k < len) chk("wr_data", mem_dat, bytes[k]);
        else chk("extra_write", k, len);
        k++;
      end
    end
    if (!done) begin chk("ack_seen", 0, 1); return; end
    chk("write_count", k, len);
    chk("hold_cycles", hold_n, 2);
    chk("run_cycles_seen", run_n, exp_cyc);
    chk("cycles", cycles, exp_cyc);
    chk("timeout", timeout, exp_to);
    chk("fin_core_reset", core_reset, 1);
    req = 1; ld_valid = 1; core_done = 1;
    repeat (5) begin
      @(negedge clk); #1;
      chk("fin_ack_held", ack, 1);
      chk("fin_cycles_held", cycles, exp_cyc);
      chk("fin_timeout_held", timeout, exp_to);
      chk("fin_no_ready", ld_ready, 0);
    end
    req = 0; core_done = 0; ld_valid = 0;
    @(negedge clk); #1;
    chk("back_idle_busy", busy, 0);
    chk("back_idle_ack", ack, 0);
    chk("idle_cycles_kept", cycles, exp_cyc);
    chk("idle_timeout_kept", timeout, exp_to);
  endtask

  initial begin
    vecs = '{'{3, 5, 5, 0}, '{0, 10, 10, 0}, '{0, 0, 20, 1}, '{0, 20, 20, 0},
             '{1, 1, 1, 0}, '{4, 19, 19, 0}, '{2, 25, 20, 1}};
    repeat (3) @(negedge clk);
    #1;
    chk("rst_core_reset", core_reset, 1);
    chk("rst_ack", ack, 0);
    chk("rst_busy", busy, 0);
    chk("rst_cycles", cycles, 0);
    chk("rst_timeout", timeout, 0);
    chk("rst_ld_ready", ld_ready, 0);
    reset = 0;
    for (int i = 0; i < 7; i++) begin
      for (int j = 0; j < 256; j++) bytes[j] = 8'($urandom);
      if (i == 0) begin bytes[0] = 8'hA1; bytes[1] = 8'hB2; bytes[2] = 8'hC3; end
      run_one(vecs[i].len, vecs[i].done_at, vecs[i].exp_cyc, vecs[i].exp_to);
    end
    begin
      int n = 0;
      @(negedge clk);
      req = 1; load_len = 5; ld_valid = 0;
      @(negedge clk);
      req = 0;
      for (int i = 0; i < 20 && n < 2; i++) begin
        ld_valid = 1; ld_data = 8'(8'h10 + n);
        #1;
        if (mem_wr_en) begin chk("mid_wr_addr", mem_addr, n); n++; end
        @(negedge clk);
      end
      chk("mid_two_written", n, 2);
      reset = 1; ld_valid = 1;
      #1;
      chk("mid_rst_wr_en", mem_wr_en, 0);
      chk("mid_rst_ready", ld_ready, 0);
      chk("mid_rst_busy", busy, 0);
      chk("mid_rst_core_reset", core_reset, 1);
      @(negedge clk);
      reset = 0;
      for (int i = 0; i < 3; i++) begin
        #1;
        chk("post_rst_busy", busy, 0);
        chk("post_rst_wr_en", mem_wr_en, 0);
        chk("post_rst_cycles", cycles, 0);
        chk("post_rst_timeout", timeout, 0);
        chk("post_rst_ack", ack, 0);
        @(negedge clk);
      end
      ld_valid = 0;
    end
    for (int i = 0; i < 8; i++) begin
      int len = $urandom_range(0, 8);
      int d = $urandom_range(1, 26);
      for (int j = 0; j < 256; j++) bytes[j] = 8'($urandom);
      run_one(len, d, (d <= TO) ? d : TO, (d > TO) ? 1 : 0);
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
